// File: rtl/ff_synchroniser_pkg.sv
// ff_sync_pkg: constants shared by the ff_synchroniser slice.
//   STAGES_MIN / STAGES_MAX : legal range for the synchroniser chain depth
//   DEFAULT_WIDTH           : default bit width of the synchronised bus
//   stages_legal()          : elaboration-time range check for STAGES
`timescale 1ns/1ps
package ff_sync_pkg;

  localparam int STAGES_MIN    = 2;
  localparam int STAGES_MAX    = 8;
  localparam int DEFAULT_WIDTH = 1;

  function automatic bit stages_legal(input int stages);
    return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
  endfunction

endpackage

// File: rtl/ff_synchroniser_sync_bit.sv
// sync_bit: single-bit multi-flop synchroniser chain in the destination domain.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, loads RESET_VAL into every stage
//   d      : asynchronous input, sampled only by the first stage
//   q      : output of the last stage, driven straight from a flop
`timescale 1ns/1ps
module sync_bit
  import ff_sync_pkg::*;
#(
  parameter int   STAGES    = STAGES_MIN,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // chain[0] is the metastability-catching flop; each later bit loads its
  // predecessor so the input travels one stage per clock.
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ff_synchroniser.sv
// ff_synchroniser: WIDTH independent multi-flop synchronisers from an
// asynchronous source into the clk_b domain, with optional edge detection.
//   clk_a      : source clock, kept for instantiation and timing constraints only
//   clk_b      : destination clock, clocks all logic
//   rst_n      : asynchronous active-low reset
//   sig_a      : asynchronous level (or Gray-coded) input bus
//   sig_b      : synchronised copy of sig_a, STAGES clk_b edges later
//   sig_b_rise : one-cycle pulse per bit when sig_b goes 0->1
//   sig_b_fall : one-cycle pulse per bit when sig_b goes 1->0
// Configuration macro: FF_SYNC_EDGE_EN enables the edge-detect flop and the
// rise/fall outputs; without it both edge outputs are tied low.
`timescale 1ns/1ps
module ff_synchroniser
  import ff_sync_pkg::*;
#(
  parameter int               STAGES    = STAGES_MIN,
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_a,
  input  logic             clk_b,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sig_a,
  output logic [WIDTH-1:0] sig_b,
  output logic [WIDTH-1:0] sig_b_rise,
  output logic [WIDTH-1:0] sig_b_fall
);

  // Refuse to build a chain that is too shallow to settle or needlessly deep.
  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("ff_synchroniser: STAGES=%0d outside %0d..%0d",
           STAGES, STAGES_MIN, STAGES_MAX);
  end

  // clk_a is deliberately not used by any logic; this sink keeps the port
  // referenced without creating a real load.
  logic unused_clk_a;
  assign unused_clk_a = clk_a;

  // One independent chain per bit: bits must not be combined before they
  // are synchronised, so multi-bit buses must be Gray-coded or level-only.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sync_bit #(
      .STAGES    (STAGES),
      .RESET_VAL (RESET_VAL[i])
    ) u_sync_bit (
      .clk   (clk_b),
      .rst_n (rst_n),
      .d     (sig_a[i]),
      .q     (sig_b[i])
    );
  end

`ifdef FF_SYNC_EDGE_EN
  // Delayed copy of sig_b; comparing it with sig_b gives a pulse in the same
  // cycle sig_b changes. Resetting it to RESET_VAL avoids a spurious pulse
  // on the first capture when sig_a already equals the reset value.
  logic [WIDTH-1:0] sig_b_q;

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      sig_b_q <= RESET_VAL;
    end else begin
      sig_b_q <= sig_b;
    end
  end

  assign sig_b_rise = sig_b & ~sig_b_q;
  assign sig_b_fall = ~sig_b & sig_b_q;
`else
  assign sig_b_rise = '0;
  assign sig_b_fall = '0;
`endif

endmodule

// File: tb/tb_ff_synchroniser.sv
// tb_ff_synchroniser: randomized self-checking bench for ff_synchroniser.
// Two instances share the clocks and reset: dut0 with default parameters and
// dut1 with STAGES=3, WIDTH=4. A history-queue model predicts every output;
// a compare process checks it on every falling clk_b edge, and a directed
// prologue pins the model with hand-computed literal values.
`timescale 1ns/1ps
module tb_ff_synchroniser;

`ifdef FF_SYNC_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  localparam int         S0   = 2;
  localparam int         S1   = 3;
  localparam logic       RST0 = 1'b0;
  localparam logic [3:0] RST1 = 4'h0;

  logic       clk_a = 1'b0;
  logic       clk_b = 1'b0;
  logic       rst_n = 1'b1;
  logic       sig_a0 = 1'b0;
  logic [3:0] sig_a1 = 4'h0;
  logic       sig_b0, rise0, fall0;
  logic [3:0] sig_b1, rise1, fall1;

  int checks   = 0;
  int failures = 0;

  always #2 clk_a = ~clk_a;
  always #5 clk_b = ~clk_b;

  ff_synchroniser dut0 (
    .clk_a      (clk_a),
    .clk_b      (clk_b),
    .rst_n      (rst_n),
    .sig_a      (sig_a0),
    .sig_b      (sig_b0),
    .sig_b_rise (rise0),
    .sig_b_fall (fall0)
  );

  ff_synchroniser #(.STAGES(S1), .WIDTH(4), .RESET_VAL(RST1)) dut1 (
    .clk_a      (clk_a),
    .clk_b      (clk_b),
    .rst_n      (rst_n),
    .sig_a      (sig_a1),
    .sig_b      (sig_b1),
    .sig_b_rise (rise1),
    .sig_b_fall (fall1)
  );

  // Model: values sampled on each rising clk_b since reset, newest first.
  // sig_b is the sample taken STAGES-1 edges before the latest one, or the
  // reset value while fewer than STAGES samples exist.
  logic       hist0[$];
  logic [3:0] hist1[$];

  always @(negedge rst_n) begin
    hist0.delete();
    hist1.delete();
  end

  always @(posedge clk_b) begin
    if (rst_n === 1'b1) begin
      hist0.push_front(sig_a0);
      hist1.push_front(sig_a1);
      if (hist0.size() > S0 + 1) void'(hist0.pop_back());
      if (hist1.size() > S1 + 1) void'(hist1.pop_back());
    end
  end

  function automatic logic expB0();
    return (hist0.size() >= S0) ? hist0[S0-1] : RST0;
  endfunction

  function automatic logic expP0();
    return (hist0.size() >= S0 + 1) ? hist0[S0] : RST0;
  endfunction

  function automatic logic [3:0] expB1();
    return (hist1.size() >= S1) ? hist1[S1-1] : RST1;
  endfunction

  function automatic logic [3:0] expP1();
    return (hist1.size() >= S1 + 1) ? hist1[S1] : RST1;
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] act,
                             input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic a0, input logic [3:0] a1);
    sig_a0 = a0;
    sig_a1 = a1;
  endtask

  task automatic waitUntil(input int t);
    #(t - int'($time));
  endtask

  // Compare process: outputs are stable at the falling clk_b edge.
  always @(negedge clk_b) begin
    logic       b0, p0;
    logic [3:0] b1, p1;
    b0 = expB0();
    p0 = expP0();
    b1 = expB1();
    p1 = expP1();
    checkOutput("m_b0",    {3'b0, sig_b0}, {3'b0, b0});
    checkOutput("m_rise0", {3'b0, rise0},  EDGE ? {3'b0, b0 & ~p0} : 4'h0);
    checkOutput("m_fall0", {3'b0, fall0},  EDGE ? {3'b0, ~b0 & p0} : 4'h0);
    checkOutput("m_b1",    sig_b1, b1);
    checkOutput("m_rise1", rise1,  EDGE ? (b1 & ~p1) : 4'h0);
    checkOutput("m_fall1", fall1,  EDGE ? (~b1 & p1) : 4'h0);
    checkOutput("m_excl0", {3'b0, rise0 & fall0}, 4'h0);
    checkOutput("m_excl1", rise1 & fall1, 4'h0);
  end

  initial begin
    logic       sv0;
    logic [3:0] sv1;
    $display("[TB] start, edge outputs %s", EDGE ? "enabled" : "disabled");

    // Reset pulse before the first clk_b edge.
    waitUntil(1);
    rst_n = 1'b0;
    waitUntil(2);
    checkOutput("rst_b0", {3'b0, sig_b0}, 4'h0);
    checkOutput("rst_b1", sig_b1, 4'h0);
    checkOutput("rst_rise1", rise1, 4'h0);
    rst_n = 1'b1;

    // Rising input: sampled at 15, visible at 25 (dut0) and 35 (dut1).
    waitUntil(10);
    applyStimulus(1'b1, 4'hA);
    waitUntil(24);
    checkOutput("lat_b0_pre", {3'b0, sig_b0}, 4'h0);
    waitUntil(26);
    checkOutput("lat_b0", {3'b0, sig_b0}, 4'h1);
    checkOutput("lat_rise0", {3'b0, rise0}, EDGE ? 4'h1 : 4'h0);
    waitUntil(27);
    applyStimulus(1'b0, 4'hA);
    waitUntil(34);
    checkOutput("lat_b1_pre", sig_b1, 4'h0);
    waitUntil(36);
    checkOutput("lat_b1", sig_b1, 4'hA);
    checkOutput("lat_rise1", rise1, EDGE ? 4'hA : 4'h0);
    checkOutput("rise0_gone", {3'b0, rise0}, 4'h0);

    // Falling input at 27: sampled 35, visible at 45.
    waitUntil(44);
    checkOutput("fall_b0_pre", {3'b0, sig_b0}, 4'h1);
    waitUntil(46);
    checkOutput("fall_b0", {3'b0, sig_b0}, 4'h0);
    checkOutput("fall_fall0", {3'b0, fall0}, EDGE ? 4'h1 : 4'h0);
    checkOutput("fall_rise0", {3'b0, rise0}, 4'h0);
    waitUntil(56);
    checkOutput("fall0_gone", {3'b0, fall0}, 4'h0);

    // Glitch between edges 55 and 65 must never reach sig_b.
    waitUntil(61);
    applyStimulus(1'b1, 4'hA);
    waitUntil(64);
    applyStimulus(1'b0, 4'hA);
    waitUntil(90);
    checkOutput("glitch_b0", {3'b0, sig_b0}, 4'h0);

    // Reset mid-propagation while sig_b is high.
    waitUntil(91);
    applyStimulus(1'b1, 4'hA);
    waitUntil(106);
    checkOutput("pre_rst_b0", {3'b0, sig_b0}, 4'h1);
    waitUntil(108);
    rst_n = 1'b0;
    waitUntil(109);
    checkOutput("async_rst_b0", {3'b0, sig_b0}, 4'h0);
    checkOutput("async_rst_b1", sig_b1, 4'h0);
    checkOutput("async_rst_rise0", {3'b0, rise0}, 4'h0);
    waitUntil(112);
    rst_n = 1'b1;
    waitUntil(124);
    checkOutput("post_rst_b0_pre", {3'b0, sig_b0}, 4'h0);
    waitUntil(126);
    checkOutput("post_rst_b0", {3'b0, sig_b0}, 4'h1);
    waitUntil(134);
    checkOutput("post_rst_b1_pre", sig_b1, 4'h0);
    waitUntil(136);
    checkOutput("post_rst_b1", sig_b1, 4'hA);

    // Randomized phase: all changes land in the first half of the low clk_b
    // phase so every sample is unambiguous; occasional glitches and resets.
    for (int n = 0; n < 400; n++) begin
      int r;
      @(negedge clk_b);
      #($urandom_range(0, 2));
      r = $urandom_range(0, 19);
      if (r < 9) begin
        applyStimulus(1'($urandom), 4'($urandom));
      end else if (r < 12) begin
        sv0 = sig_a0;
        sv1 = sig_a1;
        applyStimulus(1'($urandom), 4'($urandom));
        #($urandom_range(1, 2));
        applyStimulus(sv0, sv1);
      end else if (r == 12 && $urandom_range(0, 3) == 0) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rnd_rst_b1", sig_b1, 4'h0);
        rst_n = 1'b1;
      end
    end

    @(negedge clk_b);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ff_synchroniser.md
FF_SYNCHRONISER -- requirements
Module: ff_synchroniser

Interface
REQ-001 Parameter STAGES, default 2, number of destination-domain flops in the chain; legal range 2..8.
REQ-002 Parameter WIDTH, default 1, bit width of sig_a/sig_b; each bit synchronised independently (level signals or Gray-coded buses only).
REQ-003 Parameter RESET_VAL, default all-zeros (WIDTH bits), value loaded into every stage on reset.
REQ-004 clk_b  input  1  destination clock; the only clock driving logic.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clk_a  input  1  source-domain clock; port kept for instantiation compatibility and timing-constraint reference only, SHALL drive no logic.
REQ-007 sig_a  input  WIDTH  asynchronous source-domain level signal.
REQ-008 sig_b  output  WIDTH  synchronised copy of sig_a in clk_b domain.
REQ-009 sig_b_rise  output  WIDTH  one-clk_b-cycle pulse per bit on 0->1 transition of sig_b.
REQ-010 sig_b_fall  output  WIDTH  one-clk_b-cycle pulse per bit on 1->0 transition of sig_b.

Function
REQ-011 sig_a SHALL be sampled only by the first stage flop on rising clk_b; no combinational logic between sig_a and stage 1.
REQ-012 Stage n SHALL load stage n-1 on each rising clk_b; sig_b SHALL be the last stage output directly (registered, no logic after).
REQ-013 Latency: a sig_a change stable across a clk_b rising edge SHALL appear on sig_b exactly STAGES rising edges later, counting the sampling edge as edge 1.
REQ-014 Changes of sig_a arriving within setup/hold of a clk_b edge SHALL appear on sig_b after STAGES or STAGES+1 edges; no X propagation beyond stage 1 in simulation.
REQ-015 Pulses on sig_a shorter than one clk_b period MAY be lost; sig_b SHALL never show a value sig_a did not hold.
REQ-016 Edge outputs: sig_b_rise = sig_b & ~sig_b_q, sig_b_fall = ~sig_b & sig_b_q, where sig_b_q is one extra clk_b flop of sig_b; each pulse exactly one cycle, aligned with the sig_b change.
REQ-017 sig_b_rise and sig_b_fall SHALL never be high together for the same bit.

Reset
REQ-018 rst_n low SHALL immediately (without clk_b) force all stages and sig_b_q to RESET_VAL; sig_b = RESET_VAL, edge outputs 0.
REQ-019 After rst_n rises, first capture occurs on the next clk_b rising edge; no spurious edge pulse SHALL occur if sig_a equals RESET_VAL.
REQ-020 Reset asserted mid-propagation SHALL discard in-flight values.

Configuration
REQ-021 Macro FF_SYNC_EDGE_EN: defined -> sig_b_q flop and edge outputs per REQ-016; undefined -> flop omitted, sig_b_rise and sig_b_fall tied to 0; ports present in both cases.

Structure
REQ-022 Shared package ff_sync_pkg SHALL hold STAGES_MIN (2), STAGES_MAX (8) and default-width constant.
REQ-023 One sub-module sync_bit (single-bit STAGES-deep chain with reset) instantiated WIDTH times via generate; edge logic in top.
REQ-024 Elaboration SHALL fail for STAGES outside 2..8.

Verification
REQ-025 Defaults, clk_a period 4, clk_b period 10, rst_n released at 0: sig_a 0->1 at t=10 -> sig_b rises at the 2nd following clk_b edge (t=25), sig_b_rise high t=25..35.
REQ-026 sig_a 1->0 at t=27 -> sig_b falls at t=45, sig_b_fall one cycle, sig_b_rise stays 0.
REQ-027 sig_a high for 3 time units between clk_b edges -> sig_b stays 0, no pulses.
REQ-028 rst_n pulled low while sig_b=1, between clk_b edges -> sig_b=0 immediately; after release with sig_a=1, sig_b=1 after 2 edges.
REQ-029 STAGES=3, WIDTH=4, sig_a 4'h0->4'hA -> sig_b=4'hA after 3 edges; rise pulses on bits 1 and 3 only.
REQ-030 FF_SYNC_EDGE_EN undefined, REQ-025 stimulus -> sig_b identical, sig_b_rise/sig_b_fall constant 0.
